ladybird_uart_rx: RTL and testbench
===================================

// Module: ladybird_uart_rx
// PURPOSE
//  UART receive front end for the host-link path. Deserialises the raw uart_txd_in pin into bytes.
//  Buffers the bytes in a small FIFO and presents them over a valid/ready stream.
//  Sits directly upstream of ladybird_serial_interface, which consumes the stream and maps bytes onto bus requests.
//  Format: 8N1, LSB first, mid-bit sampling.
// PARAMETERS
//  CLK_FREQ    100_000_000  clk frequency in Hz
//  BAUD_RATE   115_200      line rate; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division); must be >= 4
//  FIFO_DEPTH  4            receive FIFO entries; power of two, >= 2
// PORTS
//  clk          input   1  single clock, all logic on posedge
//  anrst        input   1  asynchronous active-low reset
//  uart_txd_in  input   1  raw serial line, idle high, asynchronous to clk
//  rx_data      output  8  byte at FIFO head; valid only while rx_valid=1
//  rx_valid     output  1  FIFO not empty
//  rx_ready     input   1  consumer accepts the head byte when rx_valid & rx_ready
//  frame_err    output  1  sticky: stop bit sampled low
//  overrun      output  1  sticky: byte completed while FIFO full and no pop that cycle
//  parity_err   output  1  sticky parity mismatch (LADYBIRD_UART_PARITY_EN only, else tied 0)
//  err_clear    input   1  one-cycle pulse clears all sticky flags
// BEHAVIOUR
//  Reset values (anrst=0)
//   - Synchroniser flops = 1. FSM = IDLE. FIFO empty.
//   - rx_valid=0, rx_data=0, all error flags 0.
//   - Reset mid-frame discards the partial byte; after release, a new frame needs a fresh falling edge.
//  Input synchronisation
//   - uart_txd_in passes through a 2-flop synchroniser. rxd_s = second flop output.
//   - The FSM sees only rxd_s, 2 cycles behind the pin.
//  Bit counter
//   - cnt counts down to 0; "tick" = cnt==0.
//   - Reloaded to CLKS_PER_BIT-1 at every tick except where stated below.
//  FSM states and transitions
//   - IDLE: rxd_s==0 -> cnt=CLKS_PER_BIT/2-1, go START.
//   - START: at tick
//       rxd_s==1 -> glitch, back to IDLE, nothing pushed.
//       otherwise -> bit_idx=0, go DATA.
//   - DATA: at each tick, shift rxd_s into bit[bit_idx], LSB first.
//       After bit_idx==7 -> STOP (or PARITY when enabled).
//   - STOP: at tick
//       rxd_s==1 -> push byte, go IDLE.
//       rxd_s==0 -> set frame_err, drop byte, go BREAK.
//   - BREAK: wait for rxd_s==1, then go IDLE. Prevents a held-low line from re-triggering.
//  FIFO
//   - Push happens in the stop-tick cycle. rx_valid rises the following cycle (1-cycle latency from stop sample).
//   - Pop when rx_valid & rx_ready. rx_data shows the new head the next cycle.
//   - Push and pop in the same cycle: both take effect, count unchanged. This also holds when full: the push is accepted.
//   - Push while full with no pop: byte dropped, overrun set, FIFO contents unchanged.
//   - Read and write pointers are log2(FIFO_DEPTH)+1 bits; the MSB distinguishes full from empty; pointers wrap naturally.
//  Error flags
//   - Set and cleared on posedge.
//   - Set and err_clear in the same cycle: set wins.
//   - err_clear has no effect on the FSM or FIFO.
//  Back-to-back frames
//   - A start bit immediately after the stop tick is detected from IDLE.
//   - No idle gap is required between frames.
// CONFIGURATION
//  LADYBIRD_UART_PARITY_EN
//   - Defined: frame is 8E1. A PARITY state follows DATA.
//       At tick, if the sampled bit != ^byte, set parity_err.
//       The byte is still pushed if the stop bit is good.
//   - Undefined: 8N1, no PARITY state, parity_err driven constant 0.
// TESTING  (CLK_FREQ=1_600_000, BAUD_RATE=100_000 -> 16 clk/bit; FIFO_DEPTH=4)
//  T1 basic: rx_ready=1, send 0x62
//     -> exactly one rx_valid beat with rx_data=0x62, no flags.
//     -> rx_valid rises 1 cycle after the stop-bit sample.
//  T2 glitch: pulse line low 5 clk, then high
//     -> no push, FSM back in IDLE.
//     -> a following 0xA5 frame is received intact.
//  T3 framing: send 0x3C with stop bit low, hold low 40 clk, then send 0x11
//     -> frame_err=1, 0x3C not pushed, 0x11 received.
//  T4 overrun: rx_ready=0, send 0x01..0x05 back-to-back
//     -> FIFO holds 0x01..0x04, overrun=1.
//     -> draining yields 0x01,0x02,0x03,0x04, then rx_valid=0.
//     -> err_clear pulse clears overrun.
//  T5 full+pop: FIFO full; rx_ready pulsed in the exact stop-tick cycle of byte 0x05
//     -> no overrun, 0x05 accepted.
//     -> sequence 0x02..0x05 remains in the FIFO.
//  T6 reset/parity: assert anrst mid-data of 0x77
//     -> outputs at reset values, next 0x22 received cleanly.
//     -> with LADYBIRD_UART_PARITY_EN: 0x07 sent with parity bit 0 -> parity_err=1, byte 0x07 still delivered.

Source files
------------

// File: rtl/ladybird_uart_rx.sv
// ladybird_uart_rx: UART receive front end for the host-link path.
// Samples the raw serial pin through a two-flop synchroniser, recovers
// 8-bit frames (LSB first, mid-bit sampling), queues them in a small
// FIFO and hands them downstream over a valid/ready stream.
// Build option: define LADYBIRD_UART_PARITY_EN for 8E1 framing with a
// sticky parity_err flag; without it the frame is 8N1 and parity_err is 0.
module ladybird_uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       anrst,
    input  logic       uart_txd_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    input  logic       err_clear
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef LADYBIRD_UART_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic             sync_p0;
    logic             rxd_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             tick;
    logic             sample_data;
    logic             push_req;
    logic             frame_set;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [7:0]       mem [FIFO_DEPTH];
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             ovr_set;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            sync_p0 <= 1'b1;
            rxd_s   <= 1'b1;
        end else begin
            sync_p0 <= uart_txd_in;
            rxd_s   <= sync_p0;
        end
    end

    // Per-cycle frame events derived from the current state and bit tick.
    always_comb begin
        tick        = (cnt == '0);
        sample_data = (state == S_DATA) && tick;
        push_req    = (state == S_STOP) && tick && rxd_s;
        frame_set   = (state == S_STOP) && tick && !rxd_s;
    end

    // Frame FSM and bit-period counter; IDLE arms a half-bit delay so every
    // later tick lands mid-bit.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            cnt <= tick ? BIT_RELOAD : cnt - CNT_ONE;
            case (state)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state <= S_START;
                        cnt   <= HALF_RELOAD;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (rxd_s) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef LADYBIRD_UART_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef LADYBIRD_UART_PARITY_EN
                S_PARITY: begin
                    if (tick) state <= S_STOP;
                end
`endif
                S_STOP: begin
                    if (tick) state <= rxd_s ? S_IDLE : S_BREAK;
                end
                S_BREAK: begin
                    // Held-low line must return high before a new start is armed.
                    if (rxd_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Data shift register, LSB arrives first so shift in from the top.
    always_ff @(posedge clk) begin
        if (sample_data) shreg <= {rxd_s, shreg[7:1]};
    end

    // FIFO status and handshake; a pop in the same cycle frees a slot for a push.
    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        rx_valid   = !fifo_empty;
        rx_data    = fifo_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
        pop        = rx_valid && rx_ready;
        push_ok    = push_req && (!fifo_full || pop);
        ovr_set    = push_req && fifo_full && !pop;
    end

    // FIFO pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; contents are qualified by the pointers so need no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    // Sticky error flags; a new error in the clearing cycle wins.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set)      frame_err <= 1'b1;
            else if (err_clear) frame_err <= 1'b0;
            if (ovr_set)        overrun   <= 1'b1;
            else if (err_clear) overrun   <= 1'b0;
        end
    end

`ifdef LADYBIRD_UART_PARITY_EN
    logic par_set;

    // Even parity: the parity bit must equal the XOR of the data bits.
    always_comb begin
        par_set = (state == S_PARITY) && tick && (rxd_s != ^shreg);
    end

    // Sticky parity flag.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst)         parity_err <= 1'b0;
        else if (par_set)   parity_err <= 1'b1;
        else if (err_clear) parity_err <= 1'b0;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ladybird_uart_rx.sv
// Scoreboard bench for ladybird_uart_rx at 16 clocks per bit, 4-entry FIFO.
module tb_ladybird_uart_rx;

    localparam int CPB = 16;
`ifdef LADYBIRD_UART_PARITY_EN
    localparam int STOP_TICK = 171;
`else
    localparam int STOP_TICK = 155;
`endif

    logic       clk = 1'b0;
    logic       anrst;
    logic       uart_txd_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       err_clear;

    int         checks   = 0;
    int         failures = 0;
    int         beats    = 0;
    int         b0;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;

    ladybird_uart_rx #(
        .CLK_FREQ  (1_600_000),
        .BAUD_RATE (100_000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .anrst      (anrst),
        .uart_txd_in(uart_txd_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .err_clear  (err_clear)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        uart_txd_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic par_ok, input logic exp_push);
        if (exp_push) exp_q.push_back(d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef LADYBIRD_UART_PARITY_EN
        drive_bit((^d) ^ !par_ok);
`endif
        drive_bit(stop_b);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
    endtask

    // Scoreboard: every accepted beat is compared against the queue head.
    always @(negedge clk) begin
        if (anrst && rx_valid && rx_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
                check_val("exp_q_nonempty", exp_q.size(), 1);
            end else begin
                mon_exp = exp_q.pop_front();
                check_val("rx_data", {24'h0, rx_data}, {24'h0, mon_exp});
            end
        end
    end

    initial begin
        anrst       = 1'b0;
        uart_txd_in = 1'b1;
        rx_ready    = 1'b0;
        err_clear   = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_val("rst_valid", rx_valid, 0);
        check_val("rst_data", rx_data, 0);
        check_val("rst_ferr", frame_err, 0);
        check_val("rst_ovr", overrun, 0);
        check_val("rst_perr", parity_err, 0);
        anrst = 1'b1;
        repeat (5) @(posedge clk); #1;

        // T1 basic frame and push latency
        rx_ready = 1'b1;
        b0 = beats;
        fork
            send_frame(8'h62, 1'b1, 1'b1, 1'b1);
            begin
                repeat (STOP_TICK - 1) @(posedge clk); #1;
                check_val("t1_valid_pre", rx_valid, 0);
                @(posedge clk); #1;
                check_val("t1_valid_rise", rx_valid, 1);
            end
        join
        repeat (5) @(posedge clk); #1;
        check_val("t1_beats", beats - b0, 1);
        check_val("t1_q_empty", exp_q.size(), 0);
        check_val("t1_ferr", frame_err, 0);
        check_val("t1_ovr", overrun, 0);

        // T2 glitch rejection
        b0 = beats;
        uart_txd_in = 1'b0;
        repeat (5) @(posedge clk); #1;
        uart_txd_in = 1'b1;
        repeat (30) @(posedge clk); #1;
        check_val("t2_no_push", rx_valid, 0);
        check_val("t2_no_beat", beats - b0, 0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        repeat (5) @(posedge clk); #1;
        check_val("t2_beats", beats - b0, 1);
        check_val("t2_q_empty", exp_q.size(), 0);

        // T3 framing error with held-low line
        b0 = beats;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        repeat (24) @(posedge clk); #1;
        check_val("t3_ferr_set", frame_err, 1);
        uart_txd_in = 1'b1;
        repeat (20) @(posedge clk); #1;
        check_val("t3_no_push", beats - b0, 0);
        send_frame(8'h11, 1'b1, 1'b1, 1'b1);
        repeat (5) @(posedge clk); #1;
        check_val("t3_beats", beats - b0, 1);
        check_val("t3_q_empty", exp_q.size(), 0);
        check_val("t3_ferr_sticky", frame_err, 1);
        pulse_clear();
        check_val("t3_ferr_clr", frame_err, 0);

        // T4 overrun
        rx_ready = 1'b0;
        b0 = beats;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1, i <= 4);
        repeat (5) @(posedge clk); #1;
        check_val("t4_ovr_set", overrun, 1);
        check_val("t4_valid", rx_valid, 1);
        check_val("t4_head", rx_data, 8'h01);
        rx_ready = 1'b1;
        repeat (10) @(posedge clk); #1;
        check_val("t4_drained", rx_valid, 0);
        check_val("t4_beats", beats - b0, 4);
        check_val("t4_q_empty", exp_q.size(), 0);
        pulse_clear();
        check_val("t4_ovr_clr", overrun, 0);

        // T5 full FIFO with pop in the stop-tick cycle
        rx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b1, 1'b1);
        fork
            send_frame(8'h05, 1'b1, 1'b1, 1'b1);
            begin
                repeat (STOP_TICK - 1) @(posedge clk); #1;
                rx_ready = 1'b1;
                @(posedge clk); #1;
                rx_ready = 1'b0;
            end
        join
        repeat (5) @(posedge clk); #1;
        check_val("t5_no_ovr", overrun, 0);
        check_val("t5_q_left", exp_q.size(), 4);
        check_val("t5_head", rx_data, 8'h02);
        rx_ready = 1'b1;
        repeat (10) @(posedge clk); #1;
        check_val("t5_drained", rx_valid, 0);
        check_val("t5_q_empty", exp_q.size(), 0);

        // T6 reset mid-frame flushes FIFO, flags and the partial byte
        rx_ready = 1'b0;
        send_frame(8'h33, 1'b1, 1'b1, 1'b0);
        send_frame(8'h44, 1'b0, 1'b1, 1'b0);
        repeat (24) @(posedge clk); #1;
        uart_txd_in = 1'b1;
        repeat (20) @(posedge clk); #1;
        check_val("t6_pre_valid", rx_valid, 1);
        check_val("t6_pre_ferr", frame_err, 1);
        fork
            send_frame(8'h77, 1'b1, 1'b1, 1'b0);
            begin
                repeat (60) @(posedge clk); #1;
                anrst = 1'b0;
                #2;
                check_val("t6_rst_valid", rx_valid, 0);
                check_val("t6_rst_data", rx_data, 0);
                check_val("t6_rst_ferr", frame_err, 0);
                check_val("t6_rst_ovr", overrun, 0);
            end
        join
        repeat (2) @(posedge clk); #1;
        anrst = 1'b1;
        repeat (20) @(posedge clk); #1;
        check_val("t6_post_valid", rx_valid, 0);
        rx_ready = 1'b1;
        b0 = beats;
        send_frame(8'h22, 1'b1, 1'b1, 1'b1);
        repeat (5) @(posedge clk); #1;
        check_val("t6_beats", beats - b0, 1);
        check_val("t6_q_empty", exp_q.size(), 0);
        check_val("t6_ferr", frame_err, 0);

`ifdef LADYBIRD_UART_PARITY_EN
        check_val("par_clean", parity_err, 0);
        b0 = beats;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        repeat (5) @(posedge clk); #1;
        check_val("par_err_set", parity_err, 1);
        check_val("par_beats", beats - b0, 1);
        check_val("par_q_empty", exp_q.size(), 0);
        pulse_clear();
        check_val("par_err_clr", parity_err, 0);
`else
        check_val("par_tied_low", parity_err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
